// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the ALU datapath and its BCD adjust path
package alu_pkg;
   typedef enum logic [2:0] {OP_SUM = 3'd0, OP_AND = 3'd1, OP_OR = 3'd2, OP_EOR = 3'd3, OP_SHR = 3'd4} alu_op_t;
   typedef enum logic [1:0] {IDLE, DADJ, DONE} alu_state_t;
   typedef enum logic [1:0] {A_HOLD = 2'd0, A_SYS = 2'd1, A_ZERO = 2'd2, A_KEEP = 2'd3} a_sel_t;
   typedef enum logic [1:0] {B_HOLD = 2'd0, B_DB = 2'd1, B_NDB = 2'd2, B_ADL = 2'd3} b_sel_t;
endpackage

// File: rtl/alu_datapath_if.sv
// alu_datapath_if: bus, control and status signals of the ALU datapath
interface alu_datapath_if #(parameter int WIDTH = 8);
   logic [WIDTH-1:0] systemBus_IN, dataBus_IN, addressLow_IN;
   logic [1:0] a_load_SEL, b_load_SEL;
   logic [2:0] op_IN;
   logic carry_FLAG_IN, decimal_EN, start_IN;
   logic busy_OUT, done_OUT;
   logic [WIDTH-1:0] hold_REG_OUT, a_REG_OUT, b_REG_OUT;
   logic carry_FLAG_OUT, overflow_FLAG_OUT, negative_FLAG_OUT, zero_FLAG_OUT;
   modport master (
      output systemBus_IN, dataBus_IN, addressLow_IN, a_load_SEL, b_load_SEL, op_IN,
             carry_FLAG_IN, decimal_EN, start_IN,
      input  busy_OUT, done_OUT, hold_REG_OUT, a_REG_OUT, b_REG_OUT,
             carry_FLAG_OUT, overflow_FLAG_OUT, negative_FLAG_OUT, zero_FLAG_OUT
   );
   modport slave (
      input  systemBus_IN, dataBus_IN, addressLow_IN, a_load_SEL, b_load_SEL, op_IN,
             carry_FLAG_IN, decimal_EN, start_IN,
      output busy_OUT, done_OUT, hold_REG_OUT, a_REG_OUT, b_REG_OUT,
             carry_FLAG_OUT, overflow_FLAG_OUT, negative_FLAG_OUT, zero_FLAG_OUT
   );
endinterface

// File: rtl/alu_datapath_bcd_adjust.sv
// bcd_adjust: decimal correction of a binary sum, nibbles rippling low to high
module bcd_adjust #(parameter int WIDTH = 8) (
   input  logic [WIDTH-1:0]   sum,
   input  logic [WIDTH/4-1:0] nib_c,
   output logic [WIDTH-1:0]   adj,
   output logic               carry
);
   logic [4:0] v;
   logic c;
   // the incoming adjust carry is folded in before the >9 test so 0x99+1 wraps to 0x00
   always_comb begin
      adj = '0;
      c = 1'b0;
      v = '0;
      for (int n = 0; n < WIDTH/4; n++) begin
         v = {1'b0, sum[4*n +: 4]} + {4'b0, c};
         v = v + ((v > 5'd9 || nib_c[n]) ? 5'd6 : 5'd0);
         adj[4*n +: 4] = v[3:0];
         c = v[4];
      end
      carry = c;
   end
endmodule

// File: rtl/alu_datapath.sv
// alu_datapath: A/B operand registers, ALU, hold register and flags with start/done handshake
module alu_datapath
   import alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter bit DECIMAL_EN = 1'b1
) (
   input  logic phi2,
   input  logic reset_N,
   alu_datapath_if.slave bus
);
   localparam int NW = (WIDTH / 4 > 0) ? WIDTH / 4 : 1;
   alu_state_t state;
   alu_op_t op;
   a_sel_t a_sel;
   b_sel_t b_sel;
   logic [WIDTH-1:0] a_reg, b_reg, hold, res, adj;
   logic [WIDTH:0] sum;
   logic [NW-1:0] nib_c, nib_c_r;
   logic c_flag, v_flag, n_flag, z_flag, busy, done;
   logic is_sum, res_c, res_v, dec, adj_c;
   assign op = alu_op_t'(bus.op_IN);
   assign a_sel = a_sel_t'(bus.a_load_SEL);
   assign b_sel = b_sel_t'(bus.b_load_SEL);
   assign is_sum = !(op inside {OP_AND, OP_OR, OP_EOR, OP_SHR});
   assign sum = {1'b0, a_reg} + {1'b0, b_reg} + {{WIDTH{1'b0}}, bus.carry_FLAG_IN};
   assign res = op == OP_AND ? a_reg & b_reg :
                op == OP_OR  ? a_reg | b_reg :
                op == OP_EOR ? a_reg ^ b_reg :
                op == OP_SHR ? {bus.carry_FLAG_IN, a_reg[WIDTH-1:1]} : sum[WIDTH-1:0];
   assign res_c = is_sum ? sum[WIDTH] : (op == OP_SHR) && a_reg[0];
   assign res_v = is_sum && (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (res[WIDTH-1] != a_reg[WIDTH-1]);
   assign dec = DECIMAL_EN && bus.decimal_EN && is_sum;
   generate
      if (DECIMAL_EN) begin : g_bcd
         // carry out of nibble g is the carry into bit 4g+4, recovered from sum ^ a ^ b
         for (genvar g = 0; g < NW; g++) begin : g_nc
            if (g == NW - 1) begin : g_top
               assign nib_c[g] = sum[WIDTH];
            end else begin : g_mid
               assign nib_c[g] = sum[4*g+4] ^ a_reg[4*g+4] ^ b_reg[4*g+4];
            end
         end
         bcd_adjust #(.WIDTH(WIDTH)) u_bcd (.sum(hold), .nib_c(nib_c_r), .adj(adj), .carry(adj_c));
      end else begin : g_nobcd
         assign nib_c = '0;
         assign adj = hold;
         assign adj_c = 1'b0;
      end
   endgenerate
   always_ff @(posedge phi2 or negedge reset_N) begin
      if (!reset_N) begin
         state <= IDLE;
         a_reg <= '0;
         b_reg <= '0;
         hold <= '0;
         nib_c_r <= '0;
         {c_flag, v_flag, n_flag, z_flag, busy, done} <= '0;
      end else begin
         if (state != DADJ) begin
            a_reg <= a_sel == A_SYS ? bus.systemBus_IN : a_sel == A_ZERO ? '0 : a_reg;
            b_reg <= b_sel == B_DB ? bus.dataBus_IN : b_sel == B_NDB ? ~bus.dataBus_IN :
                     b_sel == B_ADL ? bus.addressLow_IN : b_reg;
         end
         done <= 1'b0;
         busy <= 1'b0;
         if (state == DADJ) begin
            hold <= adj;
            c_flag <= c_flag | adj_c;
            done <= 1'b1;
            state <= DONE;
         end else if (bus.start_IN) begin
            hold <= res;
            c_flag <= res_c;
            v_flag <= res_v;
            n_flag <= res[WIDTH-1];
            z_flag <= res == '0;
            nib_c_r <= nib_c;
            busy <= dec;
            done <= !dec;
            state <= dec ? DADJ : DONE;
         end else begin
            state <= IDLE;
         end
      end
   end
   assign bus.busy_OUT = busy;
   assign bus.done_OUT = done;
   assign bus.hold_REG_OUT = hold;
   assign bus.a_REG_OUT = a_reg;
   assign bus.b_REG_OUT = b_reg;
   assign bus.carry_FLAG_OUT = c_flag;
   assign bus.overflow_FLAG_OUT = v_flag;
   assign bus.negative_FLAG_OUT = n_flag;
   assign bus.zero_FLAG_OUT = z_flag;
endmodule

// File: tb/tb_alu_datapath.sv
// tb_alu_datapath: directed checks of the ALU datapath, 8-bit and 16-bit builds
module tb_alu_datapath;
   logic phi2 = 1'b0;
   logic reset_N = 1'b0;
   int checks = 0;
   int failures = 0;
   always #5 phi2 = ~phi2;
   alu_datapath_if #(.WIDTH(8)) bus ();
   alu_datapath_if #(.WIDTH(16)) bw ();
   alu_datapath #(.WIDTH(8), .DECIMAL_EN(1'b1)) dut (.phi2(phi2), .reset_N(reset_N), .bus(bus));
   alu_datapath #(.WIDTH(16), .DECIMAL_EN(1'b1)) dut16 (.phi2(phi2), .reset_N(reset_N), .bus(bw));
   // {done, busy, hold, C, V, N, Z}
   logic [13:0] st, e;
   logic [15:0] ab;
   logic [18:0] w;
   assign st = {bus.done_OUT, bus.busy_OUT, bus.hold_REG_OUT, bus.carry_FLAG_OUT,
                bus.overflow_FLAG_OUT, bus.negative_FLAG_OUT, bus.zero_FLAG_OUT};
   assign ab = {bus.a_REG_OUT, bus.b_REG_OUT};
   assign w = {bw.done_OUT, bw.busy_OUT, bw.hold_REG_OUT, bw.carry_FLAG_OUT};

   task automatic tick;
      @(posedge phi2);
      #1;
   endtask

   task automatic load(input logic [7:0] a, input logic [1:0] bs, input logic [7:0] db, input logic [7:0] adl);
      bus.systemBus_IN = a;
      bus.a_load_SEL = 2'd1;
      bus.b_load_SEL = bs;
      bus.dataBus_IN = db;
      bus.addressLow_IN = adl;
      tick();
      bus.a_load_SEL = 2'd0;
      bus.b_load_SEL = 2'd0;
   endtask

   task automatic go(input logic [2:0] op, input logic cin, input logic dec);
      bus.op_IN = op;
      bus.carry_FLAG_IN = cin;
      bus.decimal_EN = dec;
      bus.start_IN = 1'b1;
      tick();
      bus.start_IN = 1'b0;
   endtask

   task automatic test_reset;
      bus.systemBus_IN = 8'hFF; bus.dataBus_IN = 8'hAA; bus.addressLow_IN = 8'h55;
      bus.a_load_SEL = 2'd1; bus.b_load_SEL = 2'd1; bus.op_IN = 3'd0;
      bus.carry_FLAG_IN = 1'b1; bus.decimal_EN = 1'b1; bus.start_IN = 1'b1;
      bw.systemBus_IN = '0; bw.dataBus_IN = '0; bw.addressLow_IN = '0;
      bw.a_load_SEL = 2'd0; bw.b_load_SEL = 2'd0; bw.op_IN = 3'd0;
      bw.carry_FLAG_IN = 1'b0; bw.decimal_EN = 1'b0; bw.start_IN = 1'b0;
      tick();
      tick();
      checks++; if (st !== 14'h0) begin failures++; $display("FAIL reset_status got=%h exp=%h", st, 14'h0); end
      checks++; if (ab !== 16'h0) begin failures++; $display("FAIL reset_ab got=%h exp=%h", ab, 16'h0); end
      bus.a_load_SEL = 2'd0; bus.b_load_SEL = 2'd0; bus.start_IN = 1'b0;
      bus.carry_FLAG_IN = 1'b0; bus.decimal_EN = 1'b0;
      reset_N = 1'b1;
      tick();
      checks++; if (st !== 14'h0) begin failures++; $display("FAIL post_reset_idle got=%h exp=%h", st, 14'h0); end
   endtask

   task automatic test_binary_add;
      load(8'h50, 2'd1, 8'hD0, 8'h00);
      checks++; if (ab !== 16'h50D0) begin failures++; $display("FAIL load_ab got=%h exp=%h", ab, 16'h50D0); end
      go(3'd0, 1'b0, 1'b0);
      e = {2'b10, 8'h20, 4'b1000};
      checks++; if (st !== e) begin failures++; $display("FAIL bin_add got=%h exp=%h", st, e); end
      tick();
      e = {2'b00, 8'h20, 4'b1000};
      checks++; if (st !== e) begin failures++; $display("FAIL bin_add_hold got=%h exp=%h", st, e); end
      load(8'h50, 2'd1, 8'h50, 8'h00);
      go(3'd0, 1'b0, 1'b0);
      e = {2'b10, 8'hA0, 4'b0110};
      checks++; if (st !== e) begin failures++; $display("FAIL bin_overflow got=%h exp=%h", st, e); end
   endtask

   task automatic test_subtract;
      load(8'h05, 2'd2, 8'h01, 8'h00);
      checks++; if (ab !== 16'h05FE) begin failures++; $display("FAIL inv_load got=%h exp=%h", ab, 16'h05FE); end
      go(3'd0, 1'b1, 1'b0);
      e = {2'b10, 8'h04, 4'b1000};
      checks++; if (st !== e) begin failures++; $display("FAIL subtract got=%h exp=%h", st, e); end
   endtask

   task automatic test_decimal;
      load(8'h19, 2'd1, 8'h28, 8'h00);
      go(3'd0, 1'b0, 1'b1);
      e = {2'b01, 8'h41, 4'b0000};
      checks++; if (st !== e) begin failures++; $display("FAIL dec_busy got=%h exp=%h", st, e); end
      bus.systemBus_IN = 8'h77; bus.a_load_SEL = 2'd1; bus.start_IN = 1'b1;
      tick();
      bus.a_load_SEL = 2'd0; bus.start_IN = 1'b0;
      e = {2'b10, 8'h47, 4'b0000};
      checks++; if (st !== e) begin failures++; $display("FAIL dec_done got=%h exp=%h", st, e); end
      checks++; if (bus.a_REG_OUT !== 8'h19) begin failures++; $display("FAIL dadj_load_drop got=%h exp=%h", bus.a_REG_OUT, 8'h19); end
      tick();
      e = {2'b00, 8'h47, 4'b0000};
      checks++; if (st !== e) begin failures++; $display("FAIL dadj_start_drop got=%h exp=%h", st, e); end
      load(8'h99, 2'd1, 8'h01, 8'h00);
      go(3'd0, 1'b0, 1'b1);
      tick();
      e = {2'b10, 8'h00, 4'b1010};
      checks++; if (st !== e) begin failures++; $display("FAIL dec_wrap got=%h exp=%h", st, e); end
   endtask

   task automatic test_logic;
      logic [2:0] ops [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
      logic cins [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [11:0] exps [5] = '{{8'h01, 4'b0000}, {8'h8F, 4'b0010}, {8'h8E, 4'b0010},
                                {8'hC0, 4'b1010}, {8'h90, 4'b0010}};
      load(8'h81, 2'd1, 8'h0F, 8'h00);
      for (int i = 0; i < 5; i++) begin
         go(ops[i], cins[i], 1'b0);
         e = {2'b10, exps[i]};
         checks++; if (st !== e) begin failures++; $display("FAIL logic_op%0d got=%h exp=%h", ops[i], st, e); end
      end
      load(8'h81, 2'd3, 8'h00, 8'h81);
      go(3'd3, 1'b0, 1'b0);
      e = {2'b10, 8'h00, 4'b0001};
      checks++; if (st !== e) begin failures++; $display("FAIL zero_flag got=%h exp=%h", st, e); end
   endtask

   task automatic test_back_to_back;
      logic [2:0] ops [3] = '{3'd1, 3'd2, 3'd3};
      logic [7:0] res [3] = '{8'h01, 8'h8F, 8'h8E};
      logic [13:0] dexp [5] = '{{2'b01, 8'h41, 4'b0000}, {2'b10, 8'h47, 4'b0000},
                                {2'b01, 8'h41, 4'b0000}, {2'b10, 8'h47, 4'b0000},
                                {2'b00, 8'h47, 4'b0000}};
      load(8'h81, 2'd1, 8'h0F, 8'h00);
      bus.carry_FLAG_IN = 1'b0; bus.decimal_EN = 1'b0; bus.start_IN = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.op_IN = ops[i];
         tick();
         e = {2'b10, res[i], 1'b0, 1'b0, res[i][7], 1'b0};
         checks++; if (st !== e) begin failures++; $display("FAIL b2b_bin%0d got=%h exp=%h", i, st, e); end
      end
      bus.start_IN = 1'b0;
      load(8'h19, 2'd1, 8'h28, 8'h00);
      bus.op_IN = 3'd0; bus.decimal_EN = 1'b1; bus.start_IN = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i == 4) bus.start_IN = 1'b0;
         tick();
         checks++; if (st !== dexp[i]) begin failures++; $display("FAIL b2b_dec%0d got=%h exp=%h", i, st, dexp[i]); end
      end
   endtask

   task automatic test_reset_mid_dadj;
      load(8'h99, 2'd1, 8'h01, 8'h00);
      go(3'd0, 1'b0, 1'b1);
      e = {2'b01, 8'h9A, 4'b0010};
      checks++; if (st !== e) begin failures++; $display("FAIL pre_reset_dadj got=%h exp=%h", st, e); end
      #2 reset_N = 1'b0;
      #1;
      checks++; if (st !== 14'h0) begin failures++; $display("FAIL async_reset got=%h exp=%h", st, 14'h0); end
      checks++; if (ab !== 16'h0) begin failures++; $display("FAIL async_reset_ab got=%h exp=%h", ab, 16'h0); end
      tick();
      reset_N = 1'b1;
      tick();
      checks++; if (st !== 14'h0) begin failures++; $display("FAIL no_done_after_reset got=%h exp=%h", st, 14'h0); end
   endtask

   task automatic test_wide;
      bw.systemBus_IN = 16'h0999; bw.dataBus_IN = 16'h0001;
      bw.a_load_SEL = 2'd1; bw.b_load_SEL = 2'd1;
      tick();
      bw.a_load_SEL = 2'd0; bw.b_load_SEL = 2'd0;
      bw.op_IN = 3'd0; bw.carry_FLAG_IN = 1'b0; bw.decimal_EN = 1'b1; bw.start_IN = 1'b1;
      tick();
      bw.start_IN = 1'b0;
      checks++; if (w !== {2'b01, 16'h099A, 1'b0}) begin failures++; $display("FAIL wide_busy got=%h exp=%h", w, {2'b01, 16'h099A, 1'b0}); end
      tick();
      checks++; if (w !== {2'b10, 16'h1000, 1'b0}) begin failures++; $display("FAIL wide_dec got=%h exp=%h", w, {2'b10, 16'h1000, 1'b0}); end
   endtask

   initial begin
      test_reset();
      test_binary_add();
      test_subtract();
      test_decimal();
      test_logic();
      test_back_to_back();
      test_reset_mid_dadj();
      test_wide();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
